// File: rtl/key_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_ctrl
//  Description : Classifies debounced active-low key levels into SHORT, LONG
//                and auto-REPEAT events on a shared ms timebase. Each key
//                keeps one pending event. A round-robin arbiter places the
//                events on a single valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_ctrl #(
    parameter int NKEY     = 4,
    parameter int TICK_DIV = 200,
    parameter int LONG_MS  = 1000,
    parameter int REP_MS   = 200,
    parameter int TW       = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NKEY-1:0] key_flag,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [2:0]      ev_key,
    output logic [1:0]      ev_code,
    output logic [NKEY-1:0] ovf,
    input  logic            ovf_clr
);

    localparam int            c_PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_END = c_PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] c_LONG_END = TW'(LONG_MS - 1);
    localparam logic [TW-1:0] c_REP_END  = TW'(REP_MS - 1);
    localparam logic [1:0]    c_NONE     = 2'b00;
    localparam logic [1:0]    c_SHORT    = 2'b01;
    localparam logic [1:0]    c_LONG     = 2'b10;
    localparam logic [1:0]    c_REPEAT   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_HELD  = 2'd2
    } key_state_t;

    // ------------------------------------------------------------------
    // Millisecond timebase, free-running even while classification is off
    // ------------------------------------------------------------------
    logic [c_PW-1:0] r_presc;
    logic            w_tick;

    assign w_tick = (r_presc == c_PRESC_END);

    // Prescaler counts 0..TICK_DIV-1 and wraps on the tick cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-key press classification
    // ------------------------------------------------------------------
    logic [1:0] w_raise [NKEY];

    generate
        for (genvar g = 0; g < NKEY; g++) begin : g_key
            key_state_t    r_state;
            key_state_t    w_state_nxt;
            logic [TW-1:0] r_timer;
            logic [TW-1:0] w_timer_nxt;
            logic [1:0]    w_code;

            // Key state and held-time register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_timer <= w_timer_nxt;
                end
            end

            // Next state, timer and raised event; a release beats a same-cycle long/repeat expiry
            always_comb begin
                w_state_nxt = r_state;
                w_timer_nxt = r_timer;
                w_code      = c_NONE;
                if (!en) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (!key_flag[g]) begin
                                w_state_nxt = S_PRESS;
                                w_timer_nxt = '0;
                            end
                        end
                        S_PRESS: begin
                            if (key_flag[g]) begin
                                w_state_nxt = S_IDLE;
                                w_timer_nxt = '0;
                                w_code      = c_SHORT;
                            end else if (w_tick) begin
                                if (r_timer == c_LONG_END) begin
                                    w_state_nxt = S_HELD;
                                    w_timer_nxt = '0;
                                    w_code      = c_LONG;
                                end else begin
                                    w_timer_nxt = r_timer + TW'(1);
                                end
                            end
                        end
                        S_HELD: begin
                            if (key_flag[g]) begin
                                w_state_nxt = S_IDLE;
                                w_timer_nxt = '0;
                            end else if (w_tick) begin
                                if (r_timer == c_REP_END) begin
                                    w_timer_nxt = '0;
                                    w_code      = c_REPEAT;
                                end else begin
                                    w_timer_nxt = r_timer + TW'(1);
                                end
                            end
                        end
                        default: begin
                            w_state_nxt = S_IDLE;
                            w_timer_nxt = '0;
                        end
                    endcase
                end
            end

            assign w_raise[g] = w_code;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pending slots and round-robin arbiter
    // ------------------------------------------------------------------
    logic [1:0]      r_slot [NKEY];
    logic [2:0]      r_ptr;
    logic [7:0]      w_avail;
    logic [1:0]      w_avail_code [8];
    logic            w_load;
    logic            w_found;
    logic [2:0]      w_sel;
    logic [3:0]      w_cand;
    logic [NKEY-1:0] w_grant;
    logic [NKEY-1:0] w_drop;

    // A slot's own event is older than a freshly raised one, so it goes out
    // first; an empty slot lets the raised event bypass straight to the port.
    generate
        for (genvar g = 0; g < 8; g++) begin : g_pad
            if (g < NKEY) begin : g_real
                assign w_avail_code[g] = (r_slot[g] != c_NONE) ? r_slot[g] : w_raise[g];
            end else begin : g_zero
                assign w_avail_code[g] = c_NONE;
            end
            assign w_avail[g] = (w_avail_code[g] != c_NONE);
        end
    endgenerate

    assign w_load = !ev_valid || ev_ready;

    // First candidate after the last granted key, wrapping modulo NKEY
    always_comb begin
        w_found = 1'b0;
        w_sel   = 3'd0;
        w_cand  = 4'd0;
        for (int i = 1; i <= NKEY; i++) begin
            w_cand = {1'b0, r_ptr} + 4'(i);
            if (w_cand >= 4'(NKEY)) begin
                w_cand = w_cand - 4'(NKEY);
            end
            if (!w_found && w_avail[w_cand[2:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[2:0];
            end
        end
    end

    // Per-key grant strobe and dropped-event detection (a granted slot counts as empty)
    always_comb begin
        w_grant = '0;
        w_drop  = '0;
        for (int k = 0; k < NKEY; k++) begin
            w_grant[k] = w_load && w_found && (w_sel == 3'(k));
            w_drop[k]  = (w_raise[k] != c_NONE) && (r_slot[k] != c_NONE) && !w_grant[k];
        end
    end

    // Slot storage and sticky overflow flags; a new drop outranks ovf_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NKEY; k++) begin
                r_slot[k] <= c_NONE;
            end
            ovf <= '0;
        end else begin
            for (int k = 0; k < NKEY; k++) begin
                if (w_grant[k]) begin
                    r_slot[k] <= (r_slot[k] != c_NONE) ? w_raise[k] : c_NONE;
                end else if ((w_raise[k] != c_NONE) && (r_slot[k] == c_NONE)) begin
                    r_slot[k] <= w_raise[k];
                end
            end
            ovf <= (ovf & {NKEY{!ovf_clr}}) | w_drop;
        end
    end

    // Output register: reload when empty or when the consumer takes the beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_valid <= 1'b0;
            ev_key   <= 3'd0;
            ev_code  <= c_NONE;
            r_ptr    <= 3'd0;
        end else if (w_load) begin
            if (w_found) begin
                ev_valid <= 1'b1;
                ev_key   <= w_sel;
                ev_code  <= w_avail_code[w_sel];
                r_ptr    <= w_sel;
            end else begin
                ev_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_event_ctrl
//  Description : Self-checking bench for key_event_ctrl with a behavioural
//                event/queue model and scenario checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_ctrl;

    localparam int NKEY     = 4;
    localparam int TICK_DIV = 4;
    localparam int LONG_MS  = 10;
    localparam int REP_MS   = 3;
    localparam int TW       = 11;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       en       = 1'b1;
    logic [3:0] key_flag = 4'hF;
    logic       ev_ready = 1'b1;
    logic       ovf_clr  = 1'b0;
    logic       ev_valid;
    logic [2:0] ev_key;
    logic [1:0] ev_code;
    logic [3:0] ovf;

    int n_cmp = 0;
    int n_bad = 0;

    key_event_ctrl #(
        .NKEY(NKEY), .TICK_DIV(TICK_DIV), .LONG_MS(LONG_MS), .REP_MS(REP_MS), .TW(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .key_flag(key_flag),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_key(ev_key), .ev_code(ev_code),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: each key counts whole ms ticks since it went down.
    // Released before LONG_MS ticks -> SHORT; exactly LONG_MS ticks -> LONG;
    // every further REP_MS ticks -> REPEAT. Events queue one per key and
    // are picked round-robin after the last key served.
    // ------------------------------------------------------------------
    bit         m_valid;
    logic [2:0] m_key;
    logic [1:0] m_code;
    logic [3:0] m_ovf;
    int         m_slot   [NKEY];
    int         m_held   [NKEY];
    bit         m_active [NKEY];
    int         m_presc;
    int         m_ptr;
    int         mt_raise [NKEY];
    bit         mt_tick;
    bit         mt_load;
    int         mt_g;
    int         mt_c;
    int         mt_out;
    logic [3:0] mt_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_key = 3'd0; m_code = 2'd0; m_ovf = 4'd0;
            m_presc = 0; m_ptr = 0;
            for (int k = 0; k < NKEY; k++) begin
                m_slot[k] = 0; m_held[k] = 0; m_active[k] = 1'b0;
            end
        end else begin
            mt_tick = (m_presc == TICK_DIV - 1);
            for (int k = 0; k < NKEY; k++) begin
                mt_raise[k] = 0;
                if (!en) begin
                    m_active[k] = 1'b0; m_held[k] = 0;
                end else if (!m_active[k]) begin
                    if (!key_flag[k]) begin m_active[k] = 1'b1; m_held[k] = 0; end
                end else if (key_flag[k]) begin
                    if (m_held[k] < LONG_MS) mt_raise[k] = 1;
                    m_active[k] = 1'b0; m_held[k] = 0;
                end else if (mt_tick) begin
                    m_held[k] = m_held[k] + 1;
                    if (m_held[k] == LONG_MS) mt_raise[k] = 2;
                    else if (m_held[k] > LONG_MS && ((m_held[k] - LONG_MS) % REP_MS) == 0) mt_raise[k] = 3;
                end
            end
            mt_load = !m_valid || ev_ready;
            mt_g = -1;
            mt_out = 0;
            if (mt_load) begin
                for (int i = 1; i <= NKEY; i++) begin
                    mt_c = (m_ptr + i) % NKEY;
                    if (mt_g < 0 && (m_slot[mt_c] != 0 || mt_raise[mt_c] != 0)) mt_g = mt_c;
                end
            end
            mt_drop = 4'd0;
            for (int k = 0; k < NKEY; k++) begin
                if (k == mt_g) begin
                    if (m_slot[k] != 0) begin mt_out = m_slot[k]; m_slot[k] = mt_raise[k]; end
                    else mt_out = mt_raise[k];
                end else if (mt_raise[k] != 0) begin
                    if (m_slot[k] == 0) m_slot[k] = mt_raise[k];
                    else mt_drop[k] = 1'b1;
                end
            end
            m_ovf = (ovf_clr ? 4'd0 : m_ovf) | mt_drop;
            if (mt_load) begin
                if (mt_g >= 0) begin
                    m_valid = 1'b1; m_key = 3'(mt_g); m_code = 2'(mt_out); m_ptr = mt_g;
                end else begin
                    m_valid = 1'b0;
                end
            end
            m_presc = mt_tick ? 0 : m_presc + 1;
        end
    end

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; key_flag = 4'hF; ev_ready = 1'b1; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ev_valid, ev_key, ev_code, ovf} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_init: got v%b k%0d c%b o%b, expected all zero", ev_valid, ev_key, ev_code, ovf);
        end
        ev_ready = 1'b0;
        key_flag[3] = 1'b0;
        repeat (8) @(negedge clk);
        key_flag[3] = 1'b1;
        key_flag[0] = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_key !== 3'd3 || ev_code !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_pre: got v%b k%0d c%b, expected v1 k3 c01", ev_valid, ev_key, ev_code);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ev_valid, ev_key, ev_code, ovf} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_async: got v%b k%0d c%b o%b, expected all zero", ev_valid, ev_key, ev_code, ovf);
        end
        key_flag = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        ev_ready = 1'b1;
        repeat (25) begin
            @(negedge clk);
            n_cmp++;
            if (ev_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_quiet: got ev_valid=%b key=%0d, expected 0", ev_valid, ev_key);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_short();
        int beats = 0;
        int beat_c = -1;
        logic [2:0] bk = 3'd0;
        logic [1:0] bc = 2'd0;
        ev_ready = 1'b1;
        repeat (5) @(negedge clk);
        key_flag[2] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({ev_valid, ev_key, ev_code, ovf} !== {m_valid, m_key, m_code, m_ovf}) begin
                n_bad++;
                $display("FAIL short_model @%0t: got v%b k%0d c%b o%b, expected v%b k%0d c%b o%b",
                         $time, ev_valid, ev_key, ev_code, ovf, m_valid, m_key, m_code, m_ovf);
            end
            if (ev_valid) begin
                beats++;
                if (beat_c < 0) begin beat_c = c; bk = ev_key; bc = ev_code; end
            end
            if (c == 19) key_flag[2] = 1'b1;
        end
        n_cmp++;
        if (beats != 1 || beat_c != 20 || bk !== 3'd2 || bc !== 2'b01) begin
            n_bad++;
            $display("FAIL short_event: got %0d beats at iter %0d key %0d code %b, expected 1 beat at iter 20 key 2 code 01",
                     beats, beat_c, bk, bc);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_long();
        int et[$];
        int ec[$];
        ev_ready = 1'b1;
        repeat (5) @(negedge clk);
        key_flag[0] = 1'b0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({ev_valid, ev_key, ev_code, ovf} !== {m_valid, m_key, m_code, m_ovf}) begin
                n_bad++;
                $display("FAIL long_model @%0t: got v%b k%0d c%b o%b, expected v%b k%0d c%b o%b",
                         $time, ev_valid, ev_key, ev_code, ovf, m_valid, m_key, m_code, m_ovf);
            end
            if (ev_valid) begin et.push_back(c + 1); ec.push_back(int'(ev_code)); end
            if (c == 79) key_flag[0] = 1'b1;
        end
        n_cmp++;
        if (et.size() != 4) begin
            n_bad++;
            $display("FAIL long_count: got %0d events, expected 4 (1 LONG + 3 REPEAT)", et.size());
        end else begin
            n_cmp++;
            if (ec[0] != 2 || et[0] < 36 || et[0] > 44) begin
                n_bad++;
                $display("FAIL long_first: got code %0d at %0d cycles, expected code 2 at 36..44", ec[0], et[0]);
            end
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (ec[i] != 3 || et[i] - et[i-1] != 12) begin
                    n_bad++;
                    $display("FAIL long_repeat%0d: got code %0d spacing %0d, expected code 3 spacing 12",
                             i, ec[i], et[i] - et[i-1]);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_round_robin();
        int q[$];
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        ev_ready = 1'b0;
        key_flag = 4'b0100;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({ev_valid, ev_key, ev_code, ovf} !== {m_valid, m_key, m_code, m_ovf}) begin
                n_bad++;
                $display("FAIL rr_model @%0t: got v%b k%0d c%b o%b, expected v%b k%0d c%b o%b",
                         $time, ev_valid, ev_key, ev_code, ovf, m_valid, m_key, m_code, m_ovf);
            end
            if (c == 19) key_flag = 4'hF;
            if (c >= 21) begin
                n_cmp++;
                if (ev_valid !== 1'b1 || ev_key !== 3'd1 || ev_code !== 2'b01) begin
                    n_bad++;
                    $display("FAIL rr_stall: got v%b k%0d c%b, expected v1 k1 c01", ev_valid, ev_key, ev_code);
                end
            end
        end
        ev_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            n_cmp++;
            if ({ev_valid, ev_key, ev_code, ovf} !== {m_valid, m_key, m_code, m_ovf}) begin
                n_bad++;
                $display("FAIL rr_drain @%0t: got v%b k%0d c%b, expected v%b k%0d c%b",
                         $time, ev_valid, ev_key, ev_code, m_valid, m_key, m_code);
            end
            if (ev_valid && ev_ready) q.push_back(int'(ev_key));
            @(negedge clk);
        end
        n_cmp++;
        if (q.size() != 3 || q[0] != 1 || q[1] != 3 || q[2] != 0) begin
            n_bad++;
            $display("FAIL rr_order: got %0d beats %p, expected keys 1 3 0", q.size(), q);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_overflow();
        int q[$];
        ev_ready = 1'b0;
        for (int c = 0; c < 60; c++) begin
            key_flag[2] = !(c < 8);
            key_flag[1] = !((c >= 12 && c < 20) || (c >= 26 && c < 34));
            @(negedge clk);
            n_cmp++;
            if ({ev_valid, ev_key, ev_code, ovf} !== {m_valid, m_key, m_code, m_ovf}) begin
                n_bad++;
                $display("FAIL ovf_model @%0t: got v%b k%0d c%b o%b, expected v%b k%0d c%b o%b",
                         $time, ev_valid, ev_key, ev_code, ovf, m_valid, m_key, m_code, m_ovf);
            end
        end
        n_cmp++;
        if (ovf !== 4'b0010 || ev_key !== 3'd2) begin
            n_bad++;
            $display("FAIL ovf_set: got ovf %b key %0d, expected ovf 0010 key 2", ovf, ev_key);
        end
        ev_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (ev_valid && ev_ready) q.push_back(int'({ev_key, ev_code}));
            @(negedge clk);
        end
        n_cmp++;
        if (q.size() != 2 || q[0] != 9 || q[1] != 5) begin
            n_bad++;
            $display("FAIL ovf_drain: got %0d beats %p, expected {key,code} 9 (k2 SHORT) then 5 (k1 SHORT)", q.size(), q);
        end
        n_cmp++;
        if (ovf !== 4'b0010) begin
            n_bad++;
            $display("FAIL ovf_sticky: got %b, expected 0010", ovf);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        n_cmp++;
        if (ovf !== 4'b0000 || m_ovf !== 4'b0000) begin
            n_bad++;
            $display("FAIL ovf_clear: got %b, expected 0000", ovf);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_enable();
        int first_t = -1;
        int first_c = -1;
        int cnt = 0;
        ev_ready = 1'b1;
        en = 1'b0;
        key_flag[3] = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ev_valid !== 1'b0 || m_valid) begin
                n_bad++;
                $display("FAIL en_gate @%0t: got ev_valid=%b, expected 0", $time, ev_valid);
            end
        end
        en = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({ev_valid, ev_key, ev_code, ovf} !== {m_valid, m_key, m_code, m_ovf}) begin
                n_bad++;
                $display("FAIL en_model @%0t: got v%b k%0d c%b o%b, expected v%b k%0d c%b o%b",
                         $time, ev_valid, ev_key, ev_code, ovf, m_valid, m_key, m_code, m_ovf);
            end
            if (ev_valid) begin
                cnt++;
                if (first_t < 0) begin first_t = c + 1; first_c = int'(ev_code); key_flag[3] = 1'b1; end
            end
        end
        key_flag[3] = 1'b1;
        n_cmp++;
        if (cnt != 1 || first_c != 2 || first_t < 36 || first_t > 44) begin
            n_bad++;
            $display("FAIL en_long: got %0d events, first code %0d at %0d cycles, expected 1 LONG (2) at 36..44",
                     cnt, first_c, first_t);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({ev_valid, ev_key, ev_code, ovf} !== {m_valid, m_key, m_code, m_ovf}) begin
                n_bad++;
                $display("FAIL rand_model @%0t: got v%b k%0d c%b o%b, expected v%b k%0d c%b o%b",
                         $time, ev_valid, ev_key, ev_code, ovf, m_valid, m_key, m_code, m_ovf);
            end
            for (int k = 0; k < NKEY; k++) begin
                if ($urandom_range(0, 47) == 0) key_flag[k] = ~key_flag[k];
            end
            if ($urandom_range(0, 399) == 0) en = ~en;
            if ((c % 500) < 120) ev_ready = 1'b0;
            else ev_ready = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 63) == 0);
        end
        ovf_clr = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_round_robin();
        test_overflow();
        test_enable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Sits downstream of the per-key debounce filters. Takes their debounced active-low levels, NKEY keys in total.
- Classifies each press as SHORT, LONG or auto-REPEAT using a shared 1 ms timebase.
- Queues one pending event per key and round-robin arbitrates all keys onto a single valid/ready event port.
- The port is consumed by the panel/menu logic of the ASIC.

Parameters:
- NKEY, 4, number of keys (2..8); key index width KW = 3 bits fixed.
- TICK_DIV, 200, clk cycles per ms tick (200 kHz RC clock).
- LONG_MS, 1000, held time in ms that produces a LONG event.
- REP_MS, 200, period in ms of REPEAT events after LONG while held.
- TW, 11, width of per-key ms timer (must hold max(LONG_MS, REP_MS)).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- en  in  1  1 = classification enabled.
- key_flag  in  NKEY  debounced key levels; 0 = pressed, 1 = released.
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts event.
- ev_key  out  3  index of key owning event.
- ev_code  out  2  01 SHORT, 10 LONG, 11 REPEAT; 00 never output while ev_valid=1.
- ovf  out  NKEY  sticky per-key event-dropped flag.
- ovf_clr  in  1  clears all ovf bits.

Behaviour:

Reset (async, rst_n=0):
- ev_valid=0, ev_key=0, ev_code=0, ovf=0.
- All key FSMs IDLE, timers 0, pending slots empty, prescaler 0, RR pointer 0.

Prescaler:
- Free-running 0..TICK_DIV-1; tick=1 for one cycle when count==TICK_DIV-1, then wraps to 0.
- Runs regardless of en. Duration resolution is therefore ±1 ms.

Per-key FSM (states IDLE, PRESS, HELD):
- IDLE: key_flag[k]=0 and en=1 -> PRESS, timer<=0.
- PRESS:
  - timer increments on tick.
  - key_flag[k]=1 -> IDLE and raise SHORT.
  - Timer reaching LONG_MS on a tick -> HELD, timer<=0, raise LONG.
  - Release and reach in the same cycle: release wins (SHORT).
- HELD:
  - timer increments on tick.
  - Timer reaching REP_MS -> timer<=0, raise REPEAT.
  - key_flag[k]=1 -> IDLE, no event.
- en=0: all FSMs forced to IDLE, timers 0, no new events raised. Pending slots and output continue draining.
- A key held low when en rises is treated as a fresh press.

Pending slots (1 per key, holds code):
- Raised event with empty slot -> stored.
- Raised event with occupied slot -> dropped (existing kept), ovf[k]<=1.
- If the slot is being granted in the same cycle, it counts as empty: the new event is stored and no overflow occurs.
- ovf_clr=1 clears ovf. A simultaneous new overflow wins (bit stays 1).

Arbiter / output register:
- Load condition: ev_valid=0 or (ev_valid=1 and ev_ready=1).
- On load, pick the first occupied slot searching from index ptr+1 upward, wrapping modulo NKEY.
- On a grant:
  - ev_valid<=1, ev_key<=k, ev_code<=slot code, slot cleared, ptr<=k.
- Load condition with no slot occupied -> ev_valid<=0.
- Handshake:
  - Latency from event raise to ev_valid is 1 cycle when the output is free.
  - ev_key/ev_code are held stable while ev_valid=1 and ev_ready=0.
  - Back-to-back transfers at one per cycle are supported.
- ev_ready ignored when ev_valid=0.

Test Plan:
Sim parameters for all cases: NKEY=4, TICK_DIV=4, LONG_MS=10, REP_MS=3, ev_ready=1 unless stated.
- Reset: assert rst_n=0 mid-press with ev_valid=1 -> all outputs 0 immediately (async); after release no event until a new press.
- Short press: key_flag[2]=0 for 20 cycles then 1 -> exactly one beat ev_key=2, ev_code=01, 1 cycle after release.
- Long + repeat: key_flag[0]=0 for 80 cycles -> one LONG (10) after 40±4 cycles, then REPEAT (11) every 12 cycles (3 repeats), nothing on release.
- Round-robin: ev_ready=0, short-press keys 0, 1, 3 together, then ev_ready=1 -> ev_key sequence 1, 3, 0 (ptr starts 0), each code 01, held stable while stalled.
- Overflow: ev_ready=0, key 1 short-pressed twice -> ovf[1]=1, first SHORT kept. Then pulse ovf_clr -> ovf=0.
- Enable gating: en=0 during a 60-cycle press -> no events. Raise en while the key is still low -> the timer starts afresh and LONG arrives 40±4 cycles later.
